// File: rtl/module_captura_numeros.sv
// Operand entry: builds two decimal operands (up to MAX_DIGITS digits) from DIP digit + debounced buttons.
// Latency: raw button edge -> press pulse DEBOUNCE_CYCLES+3 cycles; operand output updates the cycle after the pulse.
// Backpressure: none; presses are consumed immediately, invalid/extra/out-of-state presses are dropped.
module module_captura_numeros #(
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter int MAX_DIGITS      = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  digit_in,
    input  logic        button,
    input  logic        next_btn,
    output logic [11:0] first_num,
    output logic [11:0] second_num,
    output logic        num_sel,
    output logic [1:0]  digit_count,
    output logic        nums_valid,
    output logic        digit_err
);

    localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [1:0]      CNT_MAX  = 2'(MAX_DIGITS);

    typedef enum logic [1:0] {S_FIRST, S_SECOND, S_DONE} state_t;

    state_t        state;
    logic [3:0]    dig_s1, dig_s2;
    logic [1:0]    raw;
    logic [1:0]    btn_s1, btn_s2;
    logic [1:0]    deb, deb_q, armed, press;
    logic [CW-1:0] deb_cnt [2];
    logic          sync_vld1, sync_vld2;
    logic          enter_p, next_p;
    logic [11:0]   acc_cur, acc_next;

    assign raw     = {next_btn, button};
    assign enter_p = press[0];
    assign next_p  = press[1];

    // Synchronizers and debouncers. A button only becomes armed once it has
    // been seen released after reset, so one held through reset never fires.
    always_ff @(posedge clk) begin
        if (rst) begin
            dig_s1    <= '0;
            dig_s2    <= '0;
            btn_s1    <= '0;
            btn_s2    <= '0;
            deb       <= '0;
            deb_q     <= '0;
            armed     <= '0;
            press     <= '0;
            sync_vld1 <= 1'b0;
            sync_vld2 <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            dig_s1    <= digit_in;
            dig_s2    <= dig_s1;
            btn_s1    <= raw;
            btn_s2    <= btn_s1;
            sync_vld1 <= 1'b1;
            sync_vld2 <= sync_vld1;
            deb_q     <= deb;
            for (int i = 0; i < 2; i++) begin
                if (btn_s2[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == CNT_LAST) begin
                    deb[i]     <= btn_s2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
                armed[i] <= armed[i] | (sync_vld2 & ~btn_s2[i]);
                press[i] <= deb[i] & ~deb_q[i] & armed[i];
            end
        end
    end

    // acc*10 + digit; operands are bounded to 999 so 12 bits never overflow.
    always_comb begin
        acc_cur  = num_sel ? second_num : first_num;
        acc_next = (acc_cur << 3) + (acc_cur << 1) + {8'd0, dig_s2};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_FIRST;
            first_num   <= '0;
            second_num  <= '0;
            num_sel     <= 1'b0;
            digit_count <= '0;
            nums_valid  <= 1'b0;
            digit_err   <= 1'b0;
        end else if (next_p) begin
            case (state)
                S_FIRST: begin
                    if (digit_count != 2'd0) begin
                        state       <= S_SECOND;
                        num_sel     <= 1'b1;
                        digit_count <= '0;
                    end
                end
                S_SECOND: begin
                    if (digit_count != 2'd0) begin
                        state      <= S_DONE;
                        nums_valid <= 1'b1;
                    end
                end
                default: begin
                    state       <= S_FIRST;
                    first_num   <= '0;
                    second_num  <= '0;
                    num_sel     <= 1'b0;
                    digit_count <= '0;
                    nums_valid  <= 1'b0;
                    digit_err   <= 1'b0;
                end
            endcase
        end else if (enter_p && state != S_DONE) begin
            if (dig_s2 > 4'd9) begin
                digit_err <= 1'b1;
            end else begin
                digit_err <= 1'b0;
                if (digit_count != CNT_MAX) begin
                    digit_count <= digit_count + 2'd1;
                    if (state == S_FIRST) begin
                        first_num <= acc_next;
                    end else begin
                        second_num <= acc_next;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_module_captura_numeros.sv
// Directed bench for module_captura_numeros with DEBOUNCE_CYCLES=4.
// Stimulus pushes hand-computed output snapshots; a monitor pops one per observed output change.
// Any output change with nothing expected, or expectations left unconsumed, is a failure.
module tb_module_captura_numeros;

    typedef struct packed {
        logic [11:0] f;
        logic [11:0] s;
        logic        sel;
        logic [1:0]  cnt;
        logic        vld;
        logic        err;
    } snap_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  digit_in = 4'd0;
    logic        button = 1'b0;
    logic        next_btn = 1'b0;
    logic [11:0] first_num, second_num;
    logic        num_sel, nums_valid, digit_err;
    logic [1:0]  digit_count;

    int    tests = 0;
    int    fails = 0;
    bit    mon_en = 1'b0;
    snap_t exp_q[$];
    string name_q[$];
    snap_t last_pushed;

    module_captura_numeros #(.DEBOUNCE_CYCLES(4), .MAX_DIGITS(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .digit_in    (digit_in),
        .button      (button),
        .next_btn    (next_btn),
        .first_num   (first_num),
        .second_num  (second_num),
        .num_sel     (num_sel),
        .digit_count (digit_count),
        .nums_valid  (nums_valid),
        .digit_err   (digit_err)
    );

    always #5 clk = ~clk;

    function automatic snap_t mk(int f, int s, int sel, int c, int v, int e);
        snap_t r;
        r.f   = 12'(f);
        r.s   = 12'(s);
        r.sel = 1'(sel);
        r.cnt = 2'(c);
        r.vld = 1'(v);
        r.err = 1'(e);
        return r;
    endfunction

    // Monitor: one comparison per observed change of the output bundle.
    initial begin
        snap_t prev, cur, e;
        string nm;
        prev = 'x;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                cur = {first_num, second_num, num_sel, digit_count, nums_valid, digit_err};
                if (cur !== prev) begin
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_change: got f=%0d s=%0d sel=%0d cnt=%0d vld=%0d err=%0d, required no change",
                                 cur.f, cur.s, cur.sel, cur.cnt, cur.vld, cur.err);
                    end else begin
                        e  = exp_q.pop_front();
                        nm = name_q.pop_front();
                        if (cur !== e) begin
                            fails++;
                            $display("FAIL %s: got f=%0d s=%0d sel=%0d cnt=%0d vld=%0d err=%0d, required f=%0d s=%0d sel=%0d cnt=%0d vld=%0d err=%0d",
                                     nm, cur.f, cur.s, cur.sel, cur.cnt, cur.vld, cur.err,
                                     e.f, e.s, e.sel, e.cnt, e.vld, e.err);
                        end
                    end
                    prev = cur;
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_s(input string nm, input snap_t e);
        if (e != last_pushed) begin
            exp_q.push_back(e);
            name_q.push_back(nm);
        end
        last_pushed = e;
    endtask

    task automatic enter(input int d, input string nm, input snap_t e);
        expect_s(nm, e);
        digit_in = 4'(d);
        cyc(1);
        button = 1'b1;
        cyc(10);
        button = 1'b0;
        cyc(10);
    endtask

    task automatic nxt(input string nm, input snap_t e);
        expect_s(nm, e);
        next_btn = 1'b1;
        cyc(10);
        next_btn = 1'b0;
        cyc(10);
    endtask

    task automatic both(input int d, input string nm, input snap_t e);
        expect_s(nm, e);
        digit_in = 4'(d);
        cyc(1);
        button   = 1'b1;
        next_btn = 1'b1;
        cyc(10);
        button   = 1'b0;
        next_btn = 1'b0;
        cyc(10);
    endtask

    initial begin
        snap_t z;
        z = mk(0, 0, 0, 0, 0, 0);
        last_pushed = 'x;
        expect_s("reset", z);
        cyc(1);
        mon_en = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(5);

        // Operand 1 = 456, operand 2 = 78
        enter(4, "d4",      mk(4,   0, 0, 1, 0, 0));
        enter(5, "d45",     mk(45,  0, 0, 2, 0, 0));
        enter(6, "d456",    mk(456, 0, 0, 3, 0, 0));
        nxt("next1",        mk(456, 0, 1, 0, 0, 0));
        enter(7, "d7",      mk(456, 7, 1, 1, 0, 0));
        enter(8, "d78",     mk(456, 78, 1, 2, 0, 0));
        nxt("next2",        mk(456, 78, 1, 2, 1, 0));
        enter(9, "done_enter", mk(456, 78, 1, 2, 1, 0));
        cyc(20);
        nxt("done_clear",   z);
        nxt("next_cnt0_first", z);

        // Digit overflow and error flag
        enter(1, "d1",      mk(1,   0, 0, 1, 0, 0));
        enter(2, "d12",     mk(12,  0, 0, 2, 0, 0));
        enter(3, "d123",    mk(123, 0, 0, 3, 0, 0));
        enter(9, "fourth_digit", mk(123, 0, 0, 3, 0, 0));
        enter(12, "bad_digit",   mk(123, 0, 0, 3, 0, 1));
        enter(5, "valid_full",   mk(123, 0, 0, 3, 0, 0));
        nxt("next3",        mk(123, 0, 1, 0, 0, 0));
        nxt("next_cnt0_second", mk(123, 0, 1, 0, 0, 0));
        enter(0, "lead0a",  mk(123, 0, 1, 1, 0, 0));
        enter(0, "lead0b",  mk(123, 0, 1, 2, 0, 0));
        enter(7, "d007",    mk(123, 7, 1, 3, 0, 0));
        nxt("next4",        mk(123, 7, 1, 3, 1, 0));
        enter(4, "done_enter2", mk(123, 7, 1, 3, 1, 0));
        nxt("done_clear2",  z);

        // Bouncing contact yields one append; a 3-cycle blip yields none
        expect_s("bounce", mk(2, 0, 0, 1, 0, 0));
        digit_in = 4'd2;
        cyc(2);
        repeat (5) begin
            button = 1'b1;
            cyc(2);
            button = 1'b0;
            cyc(2);
        end
        button = 1'b1;
        cyc(50);
        button = 1'b0;
        cyc(20);
        digit_in = 4'd3;
        cyc(2);
        button = 1'b1;
        cyc(3);
        button = 1'b0;
        cyc(20);

        // Coincident enter and next: state advances, digit dropped
        both(9, "coincide", mk(2, 0, 1, 0, 0, 0));
        enter(1, "s1",      mk(2, 1, 1, 1, 0, 0));
        nxt("next5",        mk(2, 1, 1, 1, 1, 0));
        nxt("done_clear3",  z);

        // Reset mid-entry with button held through release
        enter(3, "d3",      mk(3,  0, 0, 1, 0, 0));
        enter(4, "d34",     mk(34, 0, 0, 2, 0, 0));
        expect_s("rst_mid", z);
        digit_in = 4'd5;
        button   = 1'b1;
        rst      = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(30);
        button = 1'b0;
        cyc(20);
        enter(5, "repress", mk(5, 0, 0, 1, 0, 0));

        cyc(20);
        while (exp_q.size() > 0) begin
            snap_t e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            tests++;
            fails++;
            $display("FAIL %s: got no output change, required f=%0d s=%0d sel=%0d cnt=%0d vld=%0d err=%0d",
                     nm, e.f, e.s, e.sel, e.cnt, e.vld, e.err);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
